dmi_cpu_sequencer: RTL and testbench
====================================

Name: dmi_cpu_sequencer

Overview:
- Debug-module control core sitting between the DMI link (dmi side of the DMI handshake) and the CPU debug handshake (dmi side of the CPU debug interface).
- Decodes DMI register accesses and sequences halt, resume and reset requests plus system-bus-style memory reads and writes onto the CPU, then returns a response to the DMI.
- Allows only one outstanding CPU operation at a time.
- Bounds every CPU wait with a timeout.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles waiting for any CPU ack before returning FAILED.
- TIMER_W, 11, width of the timeout counter; must satisfy 2^TIMER_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- dmi_address  in  7  DMI register address
- dmi_wdata  in  32  DMI write data
- dmi_new_request  in  1  single-cycle request strobe
- dmi_rnw  in  1  1=read, 0=write
- dmi_handled  out  1  single-cycle completion strobe
- dmi_response  out  2  0=SUCCESS, 2=FAILED, 3=BUSY
- dmi_rdata  out  32  read data, valid when dmi_handled
- cpu_halt / cpu_resume / cpu_reset  out  1 each  level requests to the CPU
- cpu_halt_ack / cpu_resume_ack / cpu_reset_ack  in  1 each  CPU acknowledges
- cpu_running  in  1  CPU running status
- cpu_rw_addr  out  32  memory access address
- cpu_wdata  out  32  memory write data
- cpu_rnw  out  1  memory access direction
- cpu_rw_req  out  1  memory request strobe
- cpu_rw_ack  in  1  memory completion strobe
- cpu_rdata  in  32  memory read data

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All outputs and registers are cleared to 0.
  - FSM goes to IDLE.
  - Reset takes effect mid-operation: an outstanding CPU request is abandoned, and no dmi_handled is issued for it.
- Register map (word-granular 7-bit address):
  - 0x04 DATA0: R/W scratch.
  - 0x10 DMCONTROL:
    - Write: bit31 haltreq, bit30 resumereq, bit1 ndmreset.
    - Read returns {haltreq_sticky, 29'b0, ndmreset, 1'b1}.
  - 0x11 DMSTATUS, read-only:
    - bit11 allrunning = cpu_running.
    - bit9 allhalted = ~cpu_running.
    - bit17 allresumeack = sticky flag, set by resume ack, cleared by the next resumereq.
    - All other bits 0.
  - 0x39 SBADDRESS0: R/W.
  - 0x3C SBDATA0:
    - Write stores the data and launches a CPU write.
    - Read launches a CPU read and returns cpu_rdata.
  - Any other address: reads return 0 with SUCCESS; writes are ignored with SUCCESS.
- FSM states: IDLE, HALT_WAIT, RESUME_WAIT, RESET_WAIT, MEM_WAIT, RESPOND.
- IDLE:
  - On dmi_new_request, decode the access.
  - Plain register accesses go to RESPOND the next cycle, giving 2-cycle latency from request to handled.
  - DMCONTROL write with haltreq=1 → assert cpu_halt, go to HALT_WAIT.
  - DMCONTROL write with resumereq=1 and haltreq=0 → assert cpu_resume, go to RESUME_WAIT.
  - DMCONTROL write with haltreq=1 and resumereq=1 → treated as halt only.
  - DMCONTROL write with ndmreset=1 → assert cpu_reset, go to RESET_WAIT. This has priority over halt and resume.
  - SBDATA0 access → drive cpu_rw_addr = SBADDRESS0, cpu_wdata, cpu_rnw; pulse cpu_rw_req for one cycle; go to MEM_WAIT.
- *_WAIT states:
  - Hold the level request until the matching ack; then deassert it and go to RESPOND with SUCCESS.
  - The timer counts cycles in the wait state. When it reaches TIMEOUT_CYCLES, drop the request and go to RESPOND with FAILED.
  - An ack arriving in the same cycle as the timeout counts as SUCCESS.
- MEM_WAIT:
  - On cpu_rw_ack, capture cpu_rdata into SBDATA0 (reads only), then go to RESPOND.
  - On a read, SBADDRESS0 auto-increments by 4 after completion. The increment wraps modulo 2^32.
- RESPOND:
  - Pulse dmi_handled for exactly one cycle with dmi_response and dmi_rdata.
  - Return to IDLE.
- New requests while not IDLE:
  - A dmi_new_request arriving when the FSM is not IDLE is not queued.
  - It receives dmi_handled with BUSY on the following cycle. Pulse-generation priority: the in-flight response wins when both fall in the same cycle, and the BUSY response is then deferred one cycle via a 1-entry pending flag.
  - A third collision while the pending flag is set is dropped.
- dmi_rdata is 0 whenever dmi_handled=0.

Decomposition:
- Package dmi_seq_pkg holds:
  - DMI address constants (DATA0, DMCONTROL, DMSTATUS, SBADDRESS0, SBDATA0).
  - Response enum (SUCCESS=0, FAILED=2, BUSY=3).
  - FSM state enum.
  - DMCONTROL bit-index constants.
- One sub-module: dmi_ack_timer, a loadable up-counter with clear and a timeout flag output, shared by all wait states.

Test Plan:
- Reset, then write DATA0 = 0xDEADBEEF and read DATA0 → handled 2 cycles after each request, response 0, rdata 0xDEADBEEF.
- Write DMCONTROL = 0x80000000, with cpu_halt_ack returned 5 cycles later → cpu_halt high for 5 cycles, handled with response 0; DMSTATUS read gives bit9=1 when cpu_running=0.
- SBADDRESS0 = 0x1000; read SBDATA0 with the CPU returning 0x12345678 after 3 cycles → cpu_rw_req single pulse with addr 0x1000 and rnw=1; rdata 0x12345678; SBADDRESS0 reads back 0x1004. Repeat with SBADDRESS0 = 0xFFFFFFFC → wraps to 0x0.
- Resume request with no ack → cpu_resume held TIMEOUT_CYCLES cycles, then dropped; response 2.
- Second dmi_new_request during MEM_WAIT → BUSY response on the next cycle; the original access completes normally afterwards.
- Deassert rst_n during HALT_WAIT → cpu_halt 0 the next cycle, no handled pulse, FSM in IDLE; a subsequent DATA0 read returns 0.

Source files
------------

// File: rtl/dmi_seq_pkg.sv
// Shared address map, response codes, FSM states and DMCONTROL/DMSTATUS bit positions.
// No timing of its own; used by the sequencer and its bench.
package dmi_seq_pkg;

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_SBADDRESS0 = 7'h39;
  localparam logic [6:0] ADDR_SBDATA0    = 7'h3C;

  localparam int DMC_HALTREQ   = 31;
  localparam int DMC_RESUMEREQ = 30;
  localparam int DMC_NDMRESET  = 1;

  localparam int DMS_ALLRESUMEACK = 17;
  localparam int DMS_ALLRUNNING   = 11;
  localparam int DMS_ALLHALTED    = 9;

  typedef enum logic [1:0] {
    RESP_SUCCESS = 2'd0,
    RESP_FAILED  = 2'd2,
    RESP_BUSY    = 2'd3
  } dmi_resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT_WAIT,
    ST_RESUME_WAIT,
    ST_RESET_WAIT,
    ST_MEM_WAIT,
    ST_RESPOND
  } seq_state_e;

  function automatic logic [31:0] dmstatus_word(input logic running, input logic resumeack);
    logic [31:0] w;
    w                   = '0;
    w[DMS_ALLRUNNING]   = running;
    w[DMS_ALLHALTED]    = ~running;
    w[DMS_ALLRESUMEACK] = resumeack;
    return w;
  endfunction

endpackage

// File: rtl/dmi_cpu_sequencer_if.sv
// DMI link plus CPU debug handshake; master = debugger/CPU environment, slave = sequencer.
// Pure wiring, no latency; flow control is the request/handled and req/ack pairs.
interface dmi_cpu_sequencer_if;

  logic [6:0]  dmi_address;
  logic [31:0] dmi_wdata;
  logic        dmi_new_request;
  logic        dmi_rnw;
  logic        dmi_handled;
  logic [1:0]  dmi_response;
  logic [31:0] dmi_rdata;

  logic        cpu_halt;
  logic        cpu_resume;
  logic        cpu_reset;
  logic        cpu_halt_ack;
  logic        cpu_resume_ack;
  logic        cpu_reset_ack;
  logic        cpu_running;
  logic [31:0] cpu_rw_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rnw;
  logic        cpu_rw_req;
  logic        cpu_rw_ack;
  logic [31:0] cpu_rdata;

  modport master (
    output dmi_address, dmi_wdata, dmi_new_request, dmi_rnw,
    input  dmi_handled, dmi_response, dmi_rdata,
    input  cpu_halt, cpu_resume, cpu_reset, cpu_rw_addr, cpu_wdata, cpu_rnw, cpu_rw_req,
    output cpu_halt_ack, cpu_resume_ack, cpu_reset_ack, cpu_running, cpu_rw_ack, cpu_rdata
  );

  modport slave (
    input  dmi_address, dmi_wdata, dmi_new_request, dmi_rnw,
    output dmi_handled, dmi_response, dmi_rdata,
    output cpu_halt, cpu_resume, cpu_reset, cpu_rw_addr, cpu_wdata, cpu_rnw, cpu_rw_req,
    input  cpu_halt_ack, cpu_resume_ack, cpu_reset_ack, cpu_running, cpu_rw_ack, cpu_rdata
  );

endinterface

// File: rtl/dmi_ack_timer.sv
// Ack-wait timer: loadable up-counter that saturates and flags when it reaches TIMEOUT_CYCLES.
// Flag is a compare on the registered count; no backpressure.
module dmi_ack_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMER_W        = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_en,
  output logic               o_timeout
);

  logic [TIMER_W-1:0] r_count;

  assign o_timeout = (r_count == TIMER_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && !o_timeout) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/dmi_cpu_sequencer.sv
// Debug-module core: decodes DMI accesses, sequences halt/resume/reset and SB memory ops onto the CPU.
// Plain accesses answer 2 cycles after the request; one CPU op in flight, collisions answered BUSY.
module dmi_cpu_sequencer
  import dmi_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMER_W        = 11
) (
  input logic                 clk,
  input logic                 rst_n,
  dmi_cpu_sequencer_if.slave  bus
);

  seq_state_e  r_state;
  dmi_resp_e   r_resp_code;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_data0;
  logic [31:0] r_sbaddr;
  logic [31:0] r_sbdata;
  logic        r_haltreq_sticky;
  logic        r_ndmreset;
  logic        r_resumeack;
  logic        r_pending_busy;

  logic        r_handled;
  logic [1:0]  r_response;
  logic [31:0] r_rdata;
  logic        r_cpu_halt;
  logic        r_cpu_resume;
  logic        r_cpu_reset;
  logic [31:0] r_cpu_rw_addr;
  logic [31:0] r_cpu_wdata;
  logic        r_cpu_rnw;
  logic        r_cpu_rw_req;

  logic        w_busy_hit;
  logic        w_in_wait;
  logic        w_timeout;

  assign w_busy_hit = bus.dmi_new_request && (r_state != ST_IDLE);
  assign w_in_wait  = (r_state == ST_HALT_WAIT) || (r_state == ST_RESUME_WAIT) ||
                      (r_state == ST_RESET_WAIT) || (r_state == ST_MEM_WAIT);

  // Preloaded to 1 while idle so the count equals cycles spent in the wait state.
  dmi_ack_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMER_W        (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (r_state == ST_RESPOND),
    .i_load     (r_state == ST_IDLE),
    .i_load_val (TIMER_W'(1)),
    .i_en       (w_in_wait),
    .o_timeout  (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_resp_code      <= RESP_SUCCESS;
      r_resp_rdata     <= '0;
      r_data0          <= '0;
      r_sbaddr         <= '0;
      r_sbdata         <= '0;
      r_haltreq_sticky <= 1'b0;
      r_ndmreset       <= 1'b0;
      r_resumeack      <= 1'b0;
      r_pending_busy   <= 1'b0;
      r_handled        <= 1'b0;
      r_response       <= '0;
      r_rdata          <= '0;
      r_cpu_halt       <= 1'b0;
      r_cpu_resume     <= 1'b0;
      r_cpu_reset      <= 1'b0;
      r_cpu_rw_addr    <= '0;
      r_cpu_wdata      <= '0;
      r_cpu_rnw        <= 1'b0;
      r_cpu_rw_req     <= 1'b0;
    end else begin
      r_cpu_rw_req <= 1'b0;
      r_handled    <= 1'b0;
      r_response   <= RESP_SUCCESS;
      r_rdata      <= '0;

      // In-flight response owns the pulse; a colliding BUSY waits one cycle, a third is dropped.
      if (r_state == ST_RESPOND) begin
        r_handled  <= 1'b1;
        r_response <= r_resp_code;
        r_rdata    <= r_resp_rdata;
        if (w_busy_hit) r_pending_busy <= 1'b1;
      end else if (r_pending_busy || w_busy_hit) begin
        r_handled      <= 1'b1;
        r_response     <= RESP_BUSY;
        r_pending_busy <= r_pending_busy && w_busy_hit;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.dmi_new_request) begin
            r_resp_code  <= RESP_SUCCESS;
            r_resp_rdata <= '0;
            r_state      <= ST_RESPOND;
            case (bus.dmi_address)
              ADDR_DATA0: begin
                if (bus.dmi_rnw) r_resp_rdata <= r_data0;
                else             r_data0      <= bus.dmi_wdata;
              end
              ADDR_DMCONTROL: begin
                if (bus.dmi_rnw) begin
                  r_resp_rdata <= {r_haltreq_sticky, 29'b0, r_ndmreset, 1'b1};
                end else begin
                  r_ndmreset <= bus.dmi_wdata[DMC_NDMRESET];
                  if (bus.dmi_wdata[DMC_NDMRESET]) begin
                    r_cpu_reset <= 1'b1;
                    r_state     <= ST_RESET_WAIT;
                  end else if (bus.dmi_wdata[DMC_HALTREQ]) begin
                    r_cpu_halt       <= 1'b1;
                    r_haltreq_sticky <= 1'b1;
                    r_state          <= ST_HALT_WAIT;
                  end else if (bus.dmi_wdata[DMC_RESUMEREQ]) begin
                    r_cpu_resume     <= 1'b1;
                    r_haltreq_sticky <= 1'b0;
                    r_resumeack      <= 1'b0;
                    r_state          <= ST_RESUME_WAIT;
                  end
                end
              end
              ADDR_DMSTATUS: begin
                if (bus.dmi_rnw) r_resp_rdata <= dmstatus_word(bus.cpu_running, r_resumeack);
              end
              ADDR_SBADDRESS0: begin
                if (bus.dmi_rnw) r_resp_rdata <= r_sbaddr;
                else             r_sbaddr     <= bus.dmi_wdata;
              end
              ADDR_SBDATA0: begin
                r_cpu_rw_addr <= r_sbaddr;
                r_cpu_rnw     <= bus.dmi_rnw;
                r_cpu_wdata   <= bus.dmi_rnw ? r_sbdata : bus.dmi_wdata;
                r_cpu_rw_req  <= 1'b1;
                if (!bus.dmi_rnw) r_sbdata <= bus.dmi_wdata;
                r_state       <= ST_MEM_WAIT;
              end
              default: ;
            endcase
          end
        end
        ST_HALT_WAIT: begin
          if (bus.cpu_halt_ack) begin
            r_cpu_halt <= 1'b0;
            r_state    <= ST_RESPOND;
          end else if (w_timeout) begin
            r_cpu_halt  <= 1'b0;
            r_resp_code <= RESP_FAILED;
            r_state     <= ST_RESPOND;
          end
        end
        ST_RESUME_WAIT: begin
          if (bus.cpu_resume_ack) begin
            r_cpu_resume <= 1'b0;
            r_resumeack  <= 1'b1;
            r_state      <= ST_RESPOND;
          end else if (w_timeout) begin
            r_cpu_resume <= 1'b0;
            r_resp_code  <= RESP_FAILED;
            r_state      <= ST_RESPOND;
          end
        end
        ST_RESET_WAIT: begin
          if (bus.cpu_reset_ack) begin
            r_cpu_reset <= 1'b0;
            r_state     <= ST_RESPOND;
          end else if (w_timeout) begin
            r_cpu_reset <= 1'b0;
            r_resp_code <= RESP_FAILED;
            r_state     <= ST_RESPOND;
          end
        end
        ST_MEM_WAIT: begin
          if (bus.cpu_rw_ack) begin
            if (r_cpu_rnw) begin
              r_sbdata     <= bus.cpu_rdata;
              r_resp_rdata <= bus.cpu_rdata;
              r_sbaddr     <= r_sbaddr + 32'd4;
            end
            r_state <= ST_RESPOND;
          end else if (w_timeout) begin
            r_resp_code <= RESP_FAILED;
            r_state     <= ST_RESPOND;
          end
        end
        ST_RESPOND: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dmi_handled  = r_handled;
  assign bus.dmi_response = r_response;
  assign bus.dmi_rdata    = r_rdata;
  assign bus.cpu_halt     = r_cpu_halt;
  assign bus.cpu_resume   = r_cpu_resume;
  assign bus.cpu_reset    = r_cpu_reset;
  assign bus.cpu_rw_addr  = r_cpu_rw_addr;
  assign bus.cpu_wdata    = r_cpu_wdata;
  assign bus.cpu_rnw      = r_cpu_rnw;
  assign bus.cpu_rw_req   = r_cpu_rw_req;

endmodule

// File: tb/tb_dmi_cpu_sequencer.sv
// Directed bench for dmi_cpu_sequencer: inputs change on negedge, outputs sampled on negedge.
module tb_dmi_cpu_sequencer;
  import dmi_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   hi;

  always #5 clk = ~clk;

  dmi_cpu_sequencer_if bus ();

  dmi_cpu_sequencer #(
    .TIMEOUT_CYCLES (1024),
    .TIMER_W        (11)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [6:0] addr, input logic [31:0] wdata, input logic rnw);
    bus.dmi_address     = addr;
    bus.dmi_wdata       = wdata;
    bus.dmi_rnw         = rnw;
    bus.dmi_new_request = 1'b1;
  endtask

  // Plain register access: handled two negedges after the request is driven.
  task automatic access(input string tag, input logic [6:0] addr, input logic [31:0] wdata,
                        input logic rnw, input logic [31:0] exp_rdata);
    req(addr, wdata, rnw);
    @(negedge clk);
    bus.dmi_new_request = 1'b0;
    chk({tag, "/early"}, 32'(bus.dmi_handled), 32'd0);
    @(negedge clk);
    chk({tag, "/handled"}, 32'(bus.dmi_handled), 32'd1);
    chk({tag, "/resp"}, 32'(bus.dmi_response), 32'(RESP_SUCCESS));
    chk({tag, "/rdata"}, bus.dmi_rdata, exp_rdata);
    @(negedge clk);
    chk({tag, "/idle_rdata"}, {bus.dmi_rdata[31:1], bus.dmi_handled}, 32'd0);
  endtask

  // SBDATA0 access with the CPU acking on the third negedge after the request.
  task automatic mem_op(input string tag, input logic rnw, input logic [31:0] exp_addr,
                        input logic [31:0] data, input logic [31:0] exp_rdata);
    req(ADDR_SBDATA0, data, rnw);
    @(negedge clk);
    bus.dmi_new_request = 1'b0;
    chk({tag, "/req"}, 32'(bus.cpu_rw_req), 32'd1);
    chk({tag, "/addr"}, bus.cpu_rw_addr, exp_addr);
    chk({tag, "/rnw"}, 32'(bus.cpu_rnw), 32'(rnw));
    if (!rnw) chk({tag, "/wdata"}, bus.cpu_wdata, data);
    @(negedge clk);
    chk({tag, "/req_pulse"}, 32'(bus.cpu_rw_req), 32'd0);
    @(negedge clk);
    bus.cpu_rw_ack = 1'b1;
    bus.cpu_rdata  = data;
    @(negedge clk);
    bus.cpu_rw_ack = 1'b0;
    bus.cpu_rdata  = 32'h0;
    chk({tag, "/early"}, 32'(bus.dmi_handled), 32'd0);
    @(negedge clk);
    chk({tag, "/handled"}, 32'(bus.dmi_handled), 32'd1);
    chk({tag, "/resp"}, 32'(bus.dmi_response), 32'(RESP_SUCCESS));
    chk({tag, "/rdata"}, bus.dmi_rdata, exp_rdata);
    @(negedge clk);
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.dmi_address     = '0;
    bus.dmi_wdata       = '0;
    bus.dmi_new_request = 1'b0;
    bus.dmi_rnw         = 1'b0;
    bus.cpu_halt_ack    = 1'b0;
    bus.cpu_resume_ack  = 1'b0;
    bus.cpu_reset_ack   = 1'b0;
    bus.cpu_running     = 1'b0;
    bus.cpu_rw_ack      = 1'b0;
    bus.cpu_rdata       = '0;
    repeat (3) @(negedge clk);
    chk("rst/handled", 32'(bus.dmi_handled), 32'd0);
    chk("rst/rdata", bus.dmi_rdata, 32'd0);
    chk("rst/cpu_lvls", {29'b0, bus.cpu_halt, bus.cpu_resume, bus.cpu_reset}, 32'd0);
    chk("rst/rw_req", 32'(bus.cpu_rw_req), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    access("data0_wr", ADDR_DATA0, 32'hDEADBEEF, 1'b0, 32'h0);
    access("data0_rd", ADDR_DATA0, 32'h0, 1'b1, 32'hDEADBEEF);
    access("unmapped_rd", 7'h22, 32'h0, 1'b1, 32'h0);

    // Halt with the ack returned so cpu_halt stays high for exactly 5 cycles.
    req(ADDR_DMCONTROL, 32'h8000_0000, 1'b0);
    @(negedge clk);
    bus.dmi_new_request = 1'b0;
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.cpu_halt) hi++;
      if (i == 4) bus.cpu_halt_ack = 1'b1;
      if (i < 4) @(negedge clk);
    end
    @(negedge clk);
    bus.cpu_halt_ack = 1'b0;
    chk("halt/high_cycles", 32'(hi), 32'd5);
    chk("halt/dropped", 32'(bus.cpu_halt), 32'd0);
    chk("halt/early", 32'(bus.dmi_handled), 32'd0);
    @(negedge clk);
    chk("halt/handled", 32'(bus.dmi_handled), 32'd1);
    chk("halt/resp", 32'(bus.dmi_response), 32'(RESP_SUCCESS));
    @(negedge clk);
    access("dmstatus_halted", ADDR_DMSTATUS, 32'h0, 1'b1, 32'h0000_0200);
    access("dmcontrol_rd", ADDR_DMCONTROL, 32'h0, 1'b1, 32'h8000_0001);

    access("sbaddr_wr", ADDR_SBADDRESS0, 32'h0000_1000, 1'b0, 32'h0);
    mem_op("sb_rd", 1'b1, 32'h0000_1000, 32'h1234_5678, 32'h1234_5678);
    access("sbaddr_inc", ADDR_SBADDRESS0, 32'h0, 1'b1, 32'h0000_1004);
    access("sbaddr_wr2", ADDR_SBADDRESS0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    mem_op("sb_rd_wrap", 1'b1, 32'hFFFF_FFFC, 32'hA5A5_0001, 32'hA5A5_0001);
    access("sbaddr_wrap", ADDR_SBADDRESS0, 32'h0, 1'b1, 32'h0);
    mem_op("sb_wr", 1'b0, 32'h0, 32'hCAFE_F00D, 32'h0);
    access("sbaddr_no_inc", ADDR_SBADDRESS0, 32'h0, 1'b1, 32'h0);

    // Resume with no ack: held for the full timeout, then FAILED.
    req(ADDR_DMCONTROL, 32'h4000_0000, 1'b0);
    @(negedge clk);
    bus.dmi_new_request = 1'b0;
    hi = 0;
    for (int i = 0; i < 1100; i++) begin
      if (!bus.cpu_resume) break;
      hi++;
      @(negedge clk);
    end
    chk("resume_to/high_cycles", 32'(hi), 32'd1024);
    chk("resume_to/early", 32'(bus.dmi_handled), 32'd0);
    @(negedge clk);
    chk("resume_to/handled", 32'(bus.dmi_handled), 32'd1);
    chk("resume_to/resp", 32'(bus.dmi_response), 32'(RESP_FAILED));
    @(negedge clk);

    bus.cpu_running = 1'b1;
    access("dmstatus_running", ADDR_DMSTATUS, 32'h0, 1'b1, 32'h0000_0800);
    req(ADDR_DMCONTROL, 32'h4000_0000, 1'b0);
    @(negedge clk);
    bus.dmi_new_request = 1'b0;
    chk("resume/level", 32'(bus.cpu_resume), 32'd1);
    bus.cpu_resume_ack = 1'b1;
    @(negedge clk);
    bus.cpu_resume_ack = 1'b0;
    chk("resume/dropped", 32'(bus.cpu_resume), 32'd0);
    @(negedge clk);
    chk("resume/handled", 32'(bus.dmi_handled), 32'd1);
    chk("resume/resp", 32'(bus.dmi_response), 32'(RESP_SUCCESS));
    @(negedge clk);
    access("dmstatus_resumeack", ADDR_DMSTATUS, 32'h0, 1'b1, 32'h0002_0800);

    // BUSY during MEM_WAIT, then a collision with RESPOND deferred by one cycle.
    req(ADDR_SBDATA0, 32'h0, 1'b1);
    @(negedge clk);
    req(ADDR_DATA0, 32'h0, 1'b1);
    @(negedge clk);
    bus.dmi_new_request = 1'b0;
    chk("busy/handled", 32'(bus.dmi_handled), 32'd1);
    chk("busy/resp", 32'(bus.dmi_response), 32'(RESP_BUSY));
    chk("busy/rdata", bus.dmi_rdata, 32'h0);
    bus.cpu_rw_ack = 1'b1;
    bus.cpu_rdata  = 32'h0BAD_F00D;
    @(negedge clk);
    bus.cpu_rw_ack = 1'b0;
    chk("busy/gap", 32'(bus.dmi_handled), 32'd0);
    req(ADDR_DATA0, 32'h0, 1'b1);
    @(negedge clk);
    bus.dmi_new_request = 1'b0;
    chk("collide/handled", 32'(bus.dmi_handled), 32'd1);
    chk("collide/resp", 32'(bus.dmi_response), 32'(RESP_SUCCESS));
    chk("collide/rdata", bus.dmi_rdata, 32'h0BAD_F00D);
    @(negedge clk);
    chk("pending/handled", 32'(bus.dmi_handled), 32'd1);
    chk("pending/resp", 32'(bus.dmi_response), 32'(RESP_BUSY));
    @(negedge clk);
    chk("pending/cleared", 32'(bus.dmi_handled), 32'd0);
    access("sbaddr_after_busy", ADDR_SBADDRESS0, 32'h0, 1'b1, 32'h0000_0004);

    // Reset in the middle of HALT_WAIT abandons the request silently.
    req(ADDR_DMCONTROL, 32'h8000_0000, 1'b0);
    @(negedge clk);
    bus.dmi_new_request = 1'b0;
    chk("rst_mid/halt_up", 32'(bus.cpu_halt), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid/halt_down", 32'(bus.cpu_halt), 32'd0);
    chk("rst_mid/state", 32'(dut.r_state), 32'(ST_IDLE));
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.dmi_handled) hi++;
      @(negedge clk);
    end
    chk("rst_mid/no_handled", 32'(hi), 32'd0);
    access("rst_mid/data0", ADDR_DATA0, 32'h0, 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
